// File: rtl/mem_write_seq.sv
// mem_write_seq: sequential memory writer.
//   Takes data words over a valid/ready handshake and writes them to
//   consecutive addresses 0..DEPTH-1 of a single-port, synchronous-write
//   memory. busy/done let the read side begin its sweep after a fill.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - one-cycle pulse, begins a fill at address 0 (IDLE/DONE only)
//   abort     - abandons a fill in progress (LOAD only), returns to IDLE
//   in_valid  - in_data valid this cycle
//   in_data   - word to write
//   in_ready  - block accepts a word this cycle (high in LOAD)
//   mem_addr  - registered memory write address
//   mem_din   - registered memory write data
//   mem_we    - registered write enable, one cycle per accepted word
//   busy      - high in LOAD
//   done      - high in DONE, until the next start or reset
//   count     - words accepted in the current or last fill
//
// The last word's mem_we pulse lands in the first DONE cycle, so the memory
// holds the complete fill one edge after done rises.
module mem_write_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;
  logic                mem_we_q;

  // FSM, write pointer, word counter and the registered memory port.
  // mem_we defaults low each edge so it only pulses on accepting edges;
  // address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // start wins over a simultaneous abort here; abort alone is a no-op
          if (start) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            count_q  <= '0;
          end else begin
            state_q <= state_q;
          end
        end
        ST_LOAD: begin
          // abort outranks an accept on the same edge; that word is dropped
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (in_valid) begin
            mem_addr_q <= wr_ptr_q;
            mem_din_q  <= in_data;
            mem_we_q   <= 1'b1;
            count_q    <= count_q + (ADDR_W + 1)'(1);
            if (wr_ptr_q == LAST_PTR) begin
              state_q <= ST_DONE;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
          end else begin
            state_q <= ST_LOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status flags decode the state register only.
  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign count    = count_q;

endmodule

// File: tb/tb_mem_write_seq.sv
// Directed bench for mem_write_seq: one DEPTH=4 instance for the handshake,
// gap, abort, restart and reset cases, and one default DEPTH=256 instance
// for the full-range fill.
module tb_mem_write_seq;

  logic clk;
  logic rst;

  // DEPTH=4 instance signals
  logic        start4, abort4, valid4;
  logic [15:0] data4;
  logic        ready4, we4, busy4, done4;
  logic [7:0]  addr4;
  logic [15:0] din4;
  logic [8:0]  count4;

  // DEPTH=256 instance signals
  logic        start8, abort8, valid8;
  logic [15:0] data8;
  logic        ready8, we8, busy8, done8;
  logic [7:0]  addr8;
  logic [15:0] din8;
  logic [8:0]  count8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem4 [0:3];
  int wr8_total = 0;
  int wr8_zero  = 0;

  mem_write_seq #(.ADDR_W(8), .DATA_W(16), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4),
    .in_valid(valid4), .in_data(data4), .in_ready(ready4),
    .mem_addr(addr4), .mem_din(din4), .mem_we(we4),
    .busy(busy4), .done(done4), .count(count4)
  );

  mem_write_seq u_dut256 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8),
    .in_valid(valid8), .in_data(data8), .in_ready(ready8),
    .mem_addr(addr8), .mem_din(din8), .mem_we(we8),
    .busy(busy8), .done(done8), .count(count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for the small instance: captures on the edge after mem_we.
  always @(posedge clk) begin
    if (we4) mem4[addr4[1:0]] <= din4;
  end

  // Write tracker for the full-range instance.
  always @(posedge clk) begin
    if (we8) begin
      wr8_total <= wr8_total + 1;
      if (addr8 == 8'h00) wr8_zero <= wr8_zero + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start4 = 1'b0; abort4 = 1'b0; valid4 = 1'b0; data4 = 16'h0000;
    start8 = 1'b0; abort8 = 1'b0; valid8 = 1'b0; data8 = 16'h0000;
    mem4[0] = 16'h0000; mem4[1] = 16'h0000; mem4[2] = 16'h0000; mem4[3] = 16'h0000;
    step();
    step();
    rst = 1'b0;

    // ---- reset state ----
    check("rst_we", {31'd0, we4}, 32'd0);
    check("rst_ready", {31'd0, ready4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check("rst_count", {23'd0, count4}, 32'd0);
    check("rst_addr", {24'd0, addr4}, 32'd0);
    check("rst_din", {16'd0, din4}, 32'd0);
    // stays idle without start, even with data offered
    valid4 = 1'b1; data4 = 16'h0077;
    step();
    check("idle_no_we", {31'd0, we4}, 32'd0);
    check("idle_ready", {31'd0, ready4}, 32'd0);
    valid4 = 1'b0;

    // ---- full fill, continuous valid ----
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("load_ready", {31'd0, ready4}, 32'd1);
    check("load_busy", {31'd0, busy4}, 32'd1);
    check("load_count0", {23'd0, count4}, 32'd0);
    valid4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data4 = 16'h00A0 + 16'(i);
      step();
      check("fill_we", {31'd0, we4}, 32'd1);
      check("fill_addr", {24'd0, addr4}, 32'(i));
      check("fill_din", {16'd0, din4}, 32'h00A0 + 32'(i));
      check("fill_count", {23'd0, count4}, 32'(i + 1));
      check("fill_done", {31'd0, done4}, (i == 3) ? 32'd1 : 32'd0);
      check("fill_ready", {31'd0, ready4}, (i == 3) ? 32'd0 : 32'd1);
    end
    data4 = 16'h0055;
    step();
    valid4 = 1'b0;
    check("done_no_we", {31'd0, we4}, 32'd0);
    check("done_hold_addr", {24'd0, addr4}, 32'd3);
    check("done_count", {23'd0, count4}, 32'd4);
    check("mem_a0", {16'd0, mem4[0]}, 32'h00A0);
    check("mem_a1", {16'd0, mem4[1]}, 32'h00A1);
    check("mem_a2", {16'd0, mem4[2]}, 32'h00A2);
    check("mem_a3", {16'd0, mem4[3]}, 32'h00A3);

    // ---- restart from DONE, start during LOAD ignored, gapped input ----
    start4 = 1'b1;
    step();
    check("restart_done_clr", {31'd0, done4}, 32'd0);
    check("restart_count", {23'd0, count4}, 32'd0);
    check("restart_busy", {31'd0, busy4}, 32'd1);
    // start still high in LOAD: ignored while first word is accepted
    valid4 = 1'b1; data4 = 16'h00B0;
    step();
    start4 = 1'b0;
    check("gap_w0_we", {31'd0, we4}, 32'd1);
    check("gap_w0_addr", {24'd0, addr4}, 32'd0);
    check("gap_w0_count", {23'd0, count4}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      valid4 = 1'b0; data4 = 16'h00EE;
      step();
      check("gap_no_we", {31'd0, we4}, 32'd0);
      check("gap_hold_addr", {24'd0, addr4}, 32'(i - 1));
      check("gap_hold_din", {16'd0, din4}, 32'h00B0 + 32'(i - 1));
      valid4 = 1'b1; data4 = 16'h00B0 + 16'(i);
      step();
      check("gap_we", {31'd0, we4}, 32'd1);
      check("gap_addr", {24'd0, addr4}, 32'(i));
      check("gap_din", {16'd0, din4}, 32'h00B0 + 32'(i));
    end
    valid4 = 1'b0;
    check("gap_done", {31'd0, done4}, 32'd1);
    check("gap_count", {23'd0, count4}, 32'd4);
    step();
    check("mem_b0", {16'd0, mem4[0]}, 32'h00B0);
    check("mem_b3", {16'd0, mem4[3]}, 32'h00B3);

    // ---- start+abort together in DONE: start wins ----
    start4 = 1'b1; abort4 = 1'b1;
    step();
    start4 = 1'b0; abort4 = 1'b0;
    check("sa_busy", {31'd0, busy4}, 32'd1);
    check("sa_done", {31'd0, done4}, 32'd0);
    valid4 = 1'b1;
    data4 = 16'h00C0;
    step();
    data4 = 16'h00C1;
    step();
    check("ab_pre_count", {23'd0, count4}, 32'd2);
    check("ab_pre_addr", {24'd0, addr4}, 32'd1);
    // abort together with a valid word: word dropped
    abort4 = 1'b1; data4 = 16'h00FF;
    step();
    abort4 = 1'b0; valid4 = 1'b0;
    check("ab_no_we", {31'd0, we4}, 32'd0);
    check("ab_busy", {31'd0, busy4}, 32'd0);
    check("ab_ready", {31'd0, ready4}, 32'd0);
    check("ab_done", {31'd0, done4}, 32'd0);
    check("ab_count", {23'd0, count4}, 32'd2);
    check("ab_din", {16'd0, din4}, 32'h00C1);
    step();
    check("ab_mem2", {16'd0, mem4[2]}, 32'h00B2);
    // abort in IDLE ignored
    abort4 = 1'b1;
    step();
    abort4 = 1'b0;
    check("ab_idle_busy", {31'd0, busy4}, 32'd0);
    check("ab_idle_count", {23'd0, count4}, 32'd2);
    // new fill restarts at address 0
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    valid4 = 1'b1; data4 = 16'h00D0;
    step();
    check("rs_addr", {24'd0, addr4}, 32'd0);
    check("rs_din", {16'd0, din4}, 32'h00D0);
    check("rs_count", {23'd0, count4}, 32'd1);

    // ---- asynchronous reset mid-LOAD, valid still high ----
    data4 = 16'h00D1;
    rst = 1'b1;
    #1;
    check("arst_we", {31'd0, we4}, 32'd0);
    check("arst_ready", {31'd0, ready4}, 32'd0);
    check("arst_busy", {31'd0, busy4}, 32'd0);
    check("arst_done", {31'd0, done4}, 32'd0);
    check("arst_count", {23'd0, count4}, 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_we", {31'd0, we4}, 32'd0);
    check("post_rst_ready", {31'd0, ready4}, 32'd0);
    valid4 = 1'b0;

    // ---- full-range default instance, 256 words ----
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    valid8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data8 = 16'h5A00 ^ 16'(i);
      step();
      check("big_addr", {24'd0, addr8}, 32'(i));
    end
    valid8 = 1'b0;
    check("big_done", {31'd0, done8}, 32'd1);
    check("big_count", {23'd0, count8}, 32'd256);
    check("big_last_din", {16'd0, din8}, 32'h5AFF);
    step();
    step();
    check("big_total_writes", 32'(wr8_total), 32'd256);
    check("big_zero_writes", 32'(wr8_zero), 32'd1);
    check("big_idle_we", {31'd0, we8}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_write_seq.md
Name: mem_write_seq

Overview:
- Sequential memory writer; the write-side counterpart of the read-side address sequencer in the memory-display lab.
- Accepts a stream of data words over a valid/ready handshake and writes them to consecutive memory addresses, starting at 0 and ending at DEPTH-1.
- Drives a single-port synchronous-write memory (addr/din/we). Signals busy/done so the display side can start its read sweep once the fill is complete.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 16, data word width in bits.
- DEPTH, 256, number of words written per fill; must satisfy 1 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a fill from address 0.
- abort  input  1  abandons the fill in progress and returns to IDLE.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  word to be written.
- in_ready  output  1  block accepts a word this cycle.
- mem_addr  output  ADDR_W  memory write address (registered).
- mem_din  output  DATA_W  memory write data (registered).
- mem_we  output  1  memory write enable (registered, one cycle per word).
- busy  output  1  high while in LOAD.
- done  output  1  high in DONE; stays high until the next start or reset.
- count  output  ADDR_W+1  number of words accepted in the current or last fill.

Behaviour:
- Reset (async) values: state=IDLE, mem_addr=0, mem_din=0, mem_we=0, count=0, in_ready=0, busy=0, done=0. Reset asserted mid-fill forces mem_we low immediately, without waiting for a clock edge.
- States:
  - IDLE: in_ready=0.
  - LOAD: in_ready=1, busy=1.
  - DONE: in_ready=0, done=1.
- in_ready, busy and done are decoded directly from the state register only. They never depend combinationally on in_valid.
- A word is accepted at a rising edge where in_valid=1 and in_ready=1.
- Transitions:
  - IDLE/DONE with start=1 -> LOAD. On the same edge: wr_ptr=0, count=0, done cleared.
  - LOAD with abort=1 -> IDLE. abort has priority over a simultaneous accept, and that word is not written. count keeps its last value; done stays 0.
  - LOAD, accept with wr_ptr==DEPTH-1 -> DONE on the same edge.
  - LOAD, any other accept -> stays in LOAD; wr_ptr+1; count+1.
  - start while in LOAD: ignored. abort in IDLE or DONE: ignored.
  - start and abort together in IDLE or DONE: start wins.
- Write timing, one-cycle latency:
  - On the accepting edge, register mem_addr=wr_ptr, mem_din=in_data, mem_we=1.
  - The memory captures the word on the following edge.
  - mem_we is 0 on every non-accepting edge.
  - mem_addr and mem_din hold their last values while mem_we=0.
- Throughput: one word per clock while in_valid is held high. DEPTH words take DEPTH cycles from the first accept.
- Arithmetic rules:
  - wr_ptr is ADDR_W wide and never wraps past DEPTH-1 inside a fill.
  - count is ADDR_W+1 wide, so DEPTH=2^ADDR_W is representable: count=256 with the defaults.
- The final word's mem_we pulse falls in the first DONE cycle. The last memory write therefore completes one edge after done rises; consumers must wait one cycle after done rises before reading.
- in_data is ignored whenever in_ready=0, and no write occurs.

Test Plan:
- Reset behaviour: assert rst mid-LOAD with in_valid=1 -> mem_we, in_ready, busy, done and count all read 0 before the next clk edge. After release, the block stays in IDLE until start.
- Full fill, DEPTH=4: pulse start, then drive in_valid=1 continuously with data 0xA0, 0xA1, 0xA2, 0xA3 -> mem_we pulses at addresses 0, 1, 2, 3 with matching data on 4 consecutive cycles. done rises together with the addr-3 write, in_ready drops, and count=4. A memory model then holds A0..A3.
- Gapped input, DEPTH=4: toggle in_valid 1,0,1,0,... -> exactly 4 writes at addresses 0..3. No write in gap cycles. mem_addr/mem_din hold their values during gaps.
- Abort: after 2 accepts, assert abort together with in_valid=1 and data 0xFF -> state returns to IDLE, no write of 0xFF, count=2, done=0. A following start restarts at address 0.
- Restart from DONE and ignored start: issue start while in LOAD -> no effect. After DONE, pulse start again -> done clears, count resets to 0, and the new fill begins at address 0.
- Full-range default, DEPTH=256, ADDR_W=8: stream 256 words -> last write is at address 0xFF, count=9'd256, and no write ever targets address 0 a second time.
